// File: rtl/rom_fetch_if.sv
// rom_fetch_if: ROM address/data port plus the valid/ready output stream of rom_fetch.
//   rom_ad_o   : registered byte address to the ROM (master drives)
//   rom_data_i : ROM read word for the previous address (slave drives)
//   data_o     : stream word, FIFO head (master drives)
//   valid_o    : data_o holds a word (master drives)
//   ready_i    : consumer accepts the head word (slave drives)
interface rom_fetch_if #(
    parameter int AD_LEN = 32,
    parameter int BUS_WIDTH = 32
);
    logic [AD_LEN-1:0] rom_ad_o;
    logic [BUS_WIDTH-1:0] rom_data_i;
    logic [BUS_WIDTH-1:0] data_o;
    logic valid_o;
    logic ready_i;
    modport master (output rom_ad_o, data_o, valid_o, input rom_data_i, ready_i);
    modport slave (input rom_ad_o, data_o, valid_o, output rom_data_i, ready_i);
endinterface

// File: rtl/rom_fetch.sv
// rom_fetch: walks a word-aligned ROM window and streams the words out through a small FIFO.
//   clk_i, reset_i (async, active-high)
//   start_i, base_i, count_i : fetch request, sampled only when idle
//   busy_o, done_o           : fetch in progress / one-cycle completion pulse
//   err_o                    : sticky bounds-truncation flag when ROM_FETCH_BOUNDS_ERR_EN is defined, else 0
//   bus                      : rom_fetch_if master (ROM address/data, valid/ready output stream)
module rom_fetch #(
    parameter int AD_LEN = 32,
    parameter int BUS_WIDTH = 32,
    parameter logic [AD_LEN-1:0] ROM_MAX_ADDR = AD_LEN'(32'h2000),
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic [AD_LEN-1:0] base_i,
    input  logic [15:0] count_i,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    rom_fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AD_LEN-1:0] STEP = AD_LEN'(BUS_WIDTH / 8);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [AD_LEN-1:0] addr_q, addr_d, rom_ad_q, rom_ad_d;
    logic wrap_q, wrap_d;
    logic [15:0] rem_q, rem_d;
    logic infl_q, issue, oob, credit, push, pop;
    logic [PW:0] cnt_q;
    logic [PW+1:0] used;
    logic [PW-1:0] wr_q, rd_q;
    logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] last_q;
    // A carry out of the address adder means the window wrapped, which counts as out of bounds.
    assign oob = wrap_q | (addr_q >= ROM_MAX_ADDR);
    // Words already buffered plus the one still coming back from the ROM must leave room.
    assign used = (PW+2)'(cnt_q) + (PW+2)'(infl_q);
    assign credit = used < (PW+2)'(FIFO_DEPTH);
    assign push = infl_q;
    assign pop = bus.valid_o & bus.ready_i;
    assign bus.valid_o = cnt_q != '0;
    assign bus.data_o = bus.valid_o ? mem[rd_q] : last_q;
    assign bus.rom_ad_o = rom_ad_q;
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        wrap_d = wrap_q;
        rem_d = rem_q;
        rom_ad_d = rom_ad_q;
        issue = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                addr_d = base_i & ~AD_LEN'(3);
                wrap_d = 1'b0;
                rem_d = count_i;
                state_d = count_i == '0 ? DONE : FETCH;
            end
            FETCH: if (oob) begin
                state_d = DRAIN;
            end else if (credit) begin
                issue = 1'b1;
                rom_ad_d = addr_q;
                {wrap_d, addr_d} = {1'b0, addr_q} + {1'b0, STEP};
                rem_d = rem_q - 16'd1;
                state_d = rem_q == 16'd1 ? DRAIN : FETCH;
            end
            DRAIN: state_d = (!infl_q && cnt_q == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q <= '0;
            wrap_q <= 1'b0;
            rem_q <= '0;
            rom_ad_q <= '0;
            infl_q <= 1'b0;
            cnt_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            last_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wrap_q <= wrap_d;
            rem_q <= rem_d;
            rom_ad_q <= rom_ad_d;
            infl_q <= issue;
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            wr_q <= wr_q + PW'(push);
            rd_q <= rd_q + PW'(pop);
            last_q <= pop ? mem[rd_q] : last_q;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= bus.rom_data_i;
    end
`ifdef ROM_FETCH_BOUNDS_ERR_EN
    logic err_q, accept, trunc;
    assign accept = state_q == IDLE && start_i;
    assign trunc = state_q == FETCH && oob;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) err_q <= 1'b0;
        else err_q <= accept ? 1'b0 : (trunc | err_q);
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule
